cam_detect_seq: RTL and testbench
=================================

# cam_detect_seq

Frame-level sequencer for the camera blob detector. It synchronises the camera FRAME_VALID into the system clock domain and arms the detector once per frame. After end-of-frame it collects the detector's 16-bit X/Y result and publishes debounced hand coordinates with a one-cycle valid strobe for the theremin pitch/volume logic. It sits between the video input path and the detector core, and flags a stalled camera or detector.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth for frame_valid_async (≥2)
- COORD_W, 16: coordinate width
- NO_HAND, 16'hFFFF: detector sentinel for "no blob"
- MISS_LIMIT, 4: consecutive empty frames before hand_present drops (1..255)
- DONE_TIMEOUT, 4096: max clk_clk cycles from EOF to det_done
- FRAME_TIMEOUT, 2_000_000: max clk_clk cycles between SOFs while enabled

Ports:
- clk_clk, in, 1: system clock
- reset_reset_n, in, 1: asynchronous active-low reset
- enable, in, 1: run request (level)
- frame_valid_async, in, 1: camera FRAME_VALID (pixel-clock domain)
- det_start, out, 1: one-cycle arm pulse to detector
- det_done, in, 1: detector result ready (level or pulse)
- det_x, det_y, in, COORD_W: detector result, stable while det_done=1
- coord_x, coord_y, out, COORD_W: last valid hand coordinates
- coord_valid, out, 1: one-cycle strobe on coordinate update
- hand_present, out, 1: debounced hand-in-view flag
- frame_cnt, out, 16: processed-frame counter, wraps 16'hFFFF→0
- cam_timeout, out, 1: no SOF within FRAME_TIMEOUT (level)
- err_done_timeout, out, 1: sticky; detector missed DONE_TIMEOUT

## Operation
- fv_s = frame_valid_async after SYNC_STAGES flops; SOF = fv_s rising, EOF = fv_s falling (one registered previous value).
- States: IDLE, WAIT_SOF, IN_FRAME, WAIT_DONE, PUBLISH.
- IDLE: enable=1 → WAIT_SOF.
- WAIT_SOF: enable=0 → IDLE. On SOF, pulse det_start and go to IN_FRAME. A frame already in progress when enabled is skipped.
- IN_FRAME: EOF → WAIT_DONE; done-timer cleared.
- WAIT_DONE: det_done=1 → latch det_x/det_y, go to PUBLISH. If the timer reaches DONE_TIMEOUT, set err_done_timeout, treat the frame as a miss, and go to WAIT_SOF.
- PUBLISH (1 cycle), on a hit (det_x≠NO_HAND and det_y≠NO_HAND):
  - load coord_x/y
  - coord_valid=1
  - miss_cnt=0
  - hand_present=1
- PUBLISH, on a miss: miss_cnt increments, saturating at MISS_LIMIT. hand_present clears when miss_cnt reaches MISS_LIMIT. coord_x/y hold.
- PUBLISH always: frame_cnt+1; next state WAIT_SOF if enable=1, else IDLE.
- enable deassertion in IN_FRAME or WAIT_DONE does not abort; the frame completes, then IDLE.
- SOF in IN_FRAME, WAIT_DONE or PUBLISH is ignored; that frame is dropped and not counted.
- det_done outside WAIT_DONE is ignored.
- Watchdog:
  - counts cycles since the last SOF while state≠IDLE, saturating
  - sets cam_timeout at FRAME_TIMEOUT
  - clears on the next SOF or on entering IDLE
- err_done_timeout clears only on reset.

## Timing
- Reset values: state IDLE; det_start 0; coord_x/y 0; coord_valid 0; hand_present 0; frame_cnt 0; cam_timeout 0; err_done_timeout 0; miss_cnt 0; synchroniser flops 0.
- SOF latency: frame_valid_async rising before edge 0 → det_start high in the cycle after edge SYNC_STAGES+1. Default: after edge 3.
- det_done first sampled high at edge k → PUBLISH during cycle k..k+1. coord_x/y, coord_valid, hand_present and frame_cnt change at edge k+1. coord_valid stays high exactly one cycle.
- det_start and coord_valid never exceed one cycle and never occur in the same cycle.
- Reset assertion mid-frame returns to IDLE immediately (asynchronous). After release, the next full frame is the first one processed.

## Structure
- Package cam_detect_pkg:
  - state enum cam_seq_state_t
  - NO_HAND default constant
  - coordinate width constant
- Sub-module cam_fv_sync: SYNC_STAGES synchroniser plus edge detector; outputs fv_s, sof, eof.
- Remaining logic (FSM, timers, miss counter, output registers) lives in cam_detect_seq.

## Test plan
- Reset, enable=1, one frame (fv high 100 cycles), det_done 10 cycles after EOF with x=0x0120, y=0x0045:
  - det_start pulses once, 3 cycles after fv rise
  - coord=(0x0120,0x0045), coord_valid one cycle
  - hand_present=1, frame_cnt=1
- Hit, then 4 frames returning x=0xFFFF: hand_present drops at the 4th PUBLISH; coord holds 0x0120/0x0045; no coord_valid on misses.
- det_done never asserted (DONE_TIMEOUT=16): err_done_timeout sets 16 cycles after EOF; next frame processes normally; error bit stays 1.
- FRAME_TIMEOUT=1000, fv held low: cam_timeout=1 at cycle 1000; clears on the next SOF.
- enable dropped mid-frame: the frame still publishes, then IDLE. A following frame produces no det_start. Re-enable mid-frame: that frame is skipped, the next one is armed.
- reset_reset_n pulsed low in WAIT_DONE: all outputs return to reset values within the same cycle; a late det_done produces no coord_valid.

Source files
------------

// File: rtl/cam_detect_pkg.sv
// Shared types and constants for the camera frame sequencer and its synchroniser.
package cam_detect_pkg;

    localparam int COORD_W_DEF = 16;
    localparam logic [COORD_W_DEF-1:0] NO_HAND_DEF = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_IN_FRAME,
        ST_WAIT_DONE,
        ST_PUBLISH
    } cam_seq_state_t;

endpackage

// File: rtl/cam_fv_sync.sv
// Brings camera FRAME_VALID into the system clock domain and produces
// registered one-cycle start/end-of-frame pulses.
module cam_fv_sync
    import cam_detect_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic frame_valid_async,
    output logic fv_s,
    output logic sof,
    output logic eof
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   fv_prev;

    assign fv_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync_q  <= '0;
            fv_prev <= 1'b0;
            sof     <= 1'b0;
            eof     <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], frame_valid_async};
            fv_prev <= fv_s;
            sof     <= fv_s & ~fv_prev;
            eof     <= ~fv_s & fv_prev;
        end
    end

endmodule

// File: rtl/cam_detect_seq.sv
// Frame sequencer: arms the blob detector once per camera frame, collects its
// X/Y result after end-of-frame and publishes debounced hand coordinates.
module cam_detect_seq
    import cam_detect_pkg::*;
#(
    parameter int                 SYNC_STAGES   = 2,
    parameter int                 COORD_W       = COORD_W_DEF,
    parameter logic [COORD_W-1:0] NO_HAND       = COORD_W'(NO_HAND_DEF),
    parameter int                 MISS_LIMIT    = 4,
    parameter int                 DONE_TIMEOUT  = 4096,
    parameter int                 FRAME_TIMEOUT = 2_000_000
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic               enable,
    input  logic               frame_valid_async,
    output logic               det_start,
    input  logic               det_done,
    input  logic [COORD_W-1:0] det_x,
    input  logic [COORD_W-1:0] det_y,
    output logic [COORD_W-1:0] coord_x,
    output logic [COORD_W-1:0] coord_y,
    output logic               coord_valid,
    output logic               hand_present,
    output logic [15:0]        frame_cnt,
    output logic               cam_timeout,
    output logic               err_done_timeout
);

    localparam int DT_W = $clog2(DONE_TIMEOUT + 1);
    localparam int FT_W = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [DT_W-1:0] DONE_LAST = DT_W'(DONE_TIMEOUT - 1);
    localparam logic [FT_W-1:0] FT_MAX    = FT_W'(FRAME_TIMEOUT);
    localparam logic [7:0]      MISS_LIM8 = 8'(MISS_LIMIT);

    cam_seq_state_t state, state_nxt;

    logic               fv_s, sof, eof;
    logic               start_fire, eof_fire, done_fire, tmo_fire, pub_fire;
    logic [COORD_W-1:0] lat_x, lat_y;
    logic               lat_hit;
    logic [DT_W-1:0]    done_tmr;
    logic [FT_W-1:0]    wd_cnt;
    logic [7:0]         miss_cnt, miss_inc;

    cam_fv_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_fv_sync (
        .clk_clk          (clk_clk),
        .reset_reset_n    (reset_reset_n),
        .frame_valid_async(frame_valid_async),
        .fv_s             (fv_s),
        .sof              (sof),
        .eof              (eof)
    );

    assign lat_hit  = (lat_x != NO_HAND) && (lat_y != NO_HAND);
    assign miss_inc = (miss_cnt >= MISS_LIM8) ? miss_cnt : miss_cnt + 8'd1;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state <= ST_IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start_fire = 1'b0;
        eof_fire   = 1'b0;
        done_fire  = 1'b0;
        tmo_fire   = 1'b0;
        pub_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (sof && fv_s) begin
                    start_fire = 1'b1;
                    state_nxt  = ST_IN_FRAME;
                end
            end
            ST_IN_FRAME: begin
                if (eof) begin
                    eof_fire  = 1'b1;
                    state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // A result arriving on the last permitted cycle still counts.
                if (det_done) begin
                    done_fire = 1'b1;
                    state_nxt = ST_PUBLISH;
                end else if (done_tmr == DONE_LAST) begin
                    tmo_fire  = 1'b1;
                    state_nxt = ST_WAIT_SOF;
                end
            end
            ST_PUBLISH: begin
                pub_fire  = 1'b1;
                state_nxt = enable ? ST_WAIT_SOF : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            det_start        <= 1'b0;
            coord_x          <= '0;
            coord_y          <= '0;
            coord_valid      <= 1'b0;
            hand_present     <= 1'b0;
            frame_cnt        <= '0;
            err_done_timeout <= 1'b0;
            miss_cnt         <= '0;
            done_tmr         <= '0;
            lat_x            <= '0;
            lat_y            <= '0;
        end else begin
            det_start   <= start_fire;
            coord_valid <= 1'b0;

            if (eof_fire)                  done_tmr <= '0;
            else if (state == ST_WAIT_DONE) done_tmr <= done_tmr + DT_W'(1);

            if (done_fire) begin
                lat_x <= det_x;
                lat_y <= det_y;
            end

            // A detector that never answers is scored like an empty frame.
            if (tmo_fire) begin
                err_done_timeout <= 1'b1;
                miss_cnt         <= miss_inc;
                if (miss_inc == MISS_LIM8) hand_present <= 1'b0;
            end

            if (pub_fire) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (lat_hit) begin
                    coord_x      <= lat_x;
                    coord_y      <= lat_y;
                    coord_valid  <= 1'b1;
                    miss_cnt     <= '0;
                    hand_present <= 1'b1;
                end else begin
                    miss_cnt <= miss_inc;
                    if (miss_inc == MISS_LIM8) hand_present <= 1'b0;
                end
            end
        end
    end

    // Camera watchdog: cycles since the last SOF, only while the sequencer is active.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wd_cnt      <= '0;
            cam_timeout <= 1'b0;
        end else if (state == ST_IDLE || state_nxt == ST_IDLE || sof) begin
            wd_cnt      <= '0;
            cam_timeout <= 1'b0;
        end else if (wd_cnt != FT_MAX) begin
            wd_cnt <= wd_cnt + FT_W'(1);
            if (wd_cnt == FT_MAX - FT_W'(1)) cam_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cam_detect_seq.sv
// Directed scoreboard bench for cam_detect_seq: stimulus pushes expected
// publications, a negedge monitor pops them whenever coord_valid strobes.
module tb_cam_detect_seq;

    localparam int DONE_TO  = 16;
    localparam int FRAME_TO = 1000;
    localparam int MISS_LIM = 4;

    logic        clk_clk           = 1'b0;
    logic        reset_reset_n     = 1'b0;
    logic        enable            = 1'b0;
    logic        frame_valid_async = 1'b0;
    logic        det_done          = 1'b0;
    logic [15:0] det_x             = '0;
    logic [15:0] det_y             = '0;
    logic        det_start;
    logic [15:0] coord_x, coord_y;
    logic        coord_valid;
    logic        hand_present;
    logic [15:0] frame_cnt;
    logic        cam_timeout;
    logic        err_done_timeout;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] cnt;
    } pub_t;

    pub_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cv_cnt = 0;
    int          ds_cnt = 0;
    logic        prev_cv = 1'b0;

    logic [15:0] exp_x    = '0;
    logic [15:0] exp_y    = '0;
    logic [15:0] exp_cnt  = '0;
    logic        exp_hand = 1'b0;
    int          exp_miss = 0;

    cam_detect_seq #(
        .SYNC_STAGES  (2),
        .COORD_W      (16),
        .NO_HAND      (16'hFFFF),
        .MISS_LIMIT   (MISS_LIM),
        .DONE_TIMEOUT (DONE_TO),
        .FRAME_TIMEOUT(FRAME_TO)
    ) dut (
        .clk_clk          (clk_clk),
        .reset_reset_n    (reset_reset_n),
        .enable           (enable),
        .frame_valid_async(frame_valid_async),
        .det_start        (det_start),
        .det_done         (det_done),
        .det_x            (det_x),
        .det_y            (det_y),
        .coord_x          (coord_x),
        .coord_y          (coord_y),
        .coord_valid      (coord_valid),
        .hand_present     (hand_present),
        .frame_cnt        (frame_cnt),
        .cam_timeout      (cam_timeout),
        .err_done_timeout (err_done_timeout)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    // Reference behaviour of one detector result; pushes a publication on a hit.
    task automatic model_frame(input logic [15:0] x, input logic [15:0] y, input bit counted);
        if (x != 16'hFFFF && y != 16'hFFFF) begin
            exp_x    = x;
            exp_y    = y;
            exp_miss = 0;
            exp_hand = 1'b1;
            if (counted) sb_q.push_back('{x: x, y: y, cnt: exp_cnt + 16'd1});
        end else begin
            if (exp_miss < MISS_LIM) exp_miss++;
            if (exp_miss == MISS_LIM) exp_hand = 1'b0;
        end
        if (counted) exp_cnt = exp_cnt + 16'd1;
    endtask

    // One camera frame of 'high' cycles; det_start is expected only when armed.
    task automatic applyStimulus(input int high, input bit armed, input bit drop_en,
                                 input logic [15:0] x, input logic [15:0] y);
        frame_valid_async = 1'b1;
        tick(3);
        checkOutput("det_start_early", det_start, 0);
        tick(1);
        checkOutput("det_start_pulse", det_start, armed);
        tick(1);
        checkOutput("det_start_width", det_start, 0);
        if (drop_en) enable = 1'b0;
        tick(high - 5);
        frame_valid_async = 1'b0;
        if (armed) begin
            tick(10);
            model_frame(x, y, 1'b1);
            det_x    = x;
            det_y    = y;
            det_done = 1'b1;
            tick(2);
            det_done = 1'b0;
            tick(1);
            checkOutput("hand_present", hand_present, exp_hand);
            checkOutput("frame_cnt", frame_cnt, exp_cnt);
            checkOutput("coord_x", coord_x, exp_x);
            checkOutput("coord_y", coord_y, exp_y);
        end
        tick(10);
    endtask

    // Monitor: every coord_valid strobe must match the head of the scoreboard.
    always @(negedge clk_clk) begin
        if (reset_reset_n) begin
            if (det_start) ds_cnt++;
            if (coord_valid) begin
                cv_cnt++;
                checkOutput("cv_with_start", det_start, 0);
                checkOutput("cv_width", prev_cv, 0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_cv: got coord_valid=1, expected none at %0t", $time);
                end else begin
                    pub_t e;
                    e = sb_q.pop_front();
                    checkOutput("pub_x", coord_x, e.x);
                    checkOutput("pub_y", coord_y, e.y);
                    checkOutput("pub_cnt", frame_cnt, e.cnt);
                    checkOutput("pub_hand", hand_present, 1);
                end
            end
            prev_cv = coord_valid;
        end else begin
            prev_cv = 1'b0;
        end
    end

    initial begin
        int ds_before;
        int cv_before;

        $display("[TB] cam_detect_seq bench start");
        tick(3);
        checkOutput("rst_det_start", det_start, 0);
        checkOutput("rst_coord_x", coord_x, 0);
        checkOutput("rst_coord_valid", coord_valid, 0);
        checkOutput("rst_hand", hand_present, 0);
        checkOutput("rst_frame_cnt", frame_cnt, 0);
        checkOutput("rst_cam_timeout", cam_timeout, 0);
        checkOutput("rst_err", err_done_timeout, 0);
        reset_reset_n = 1'b1;
        tick(2);
        enable = 1'b1;
        tick(5);

        // Basic hit, then a run of empty frames that debounces hand_present away.
        applyStimulus(100, 1'b1, 1'b0, 16'h0120, 16'h0045);
        applyStimulus(100, 1'b1, 1'b0, 16'hFFFF, 16'h0010);
        applyStimulus(100, 1'b1, 1'b0, 16'hFFFF, 16'h0010);
        applyStimulus(100, 1'b1, 1'b0, 16'h0010, 16'hFFFF);
        applyStimulus(100, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
        applyStimulus(100, 1'b1, 1'b0, 16'h0200, 16'h0300);

        // Detector never answers.
        frame_valid_async = 1'b1;
        tick(100);
        frame_valid_async = 1'b0;
        tick(19);
        checkOutput("err_before_limit", err_done_timeout, 0);
        tick(1);
        checkOutput("err_at_limit", err_done_timeout, 1);
        model_frame(16'hFFFF, 16'hFFFF, 1'b0);
        tick(10);
        checkOutput("tmo_hand", hand_present, exp_hand);
        checkOutput("tmo_frame_cnt", frame_cnt, exp_cnt);
        applyStimulus(100, 1'b1, 1'b0, 16'h0011, 16'h0022);
        checkOutput("err_sticky", err_done_timeout, 1);

        // Camera watchdog with FRAME_VALID held low.
        enable = 1'b0;
        tick(3);
        checkOutput("wd_idle", cam_timeout, 0);
        enable = 1'b1;
        tick(990);
        checkOutput("wd_before", cam_timeout, 0);
        tick(20);
        checkOutput("wd_fired", cam_timeout, 1);
        applyStimulus(100, 1'b1, 1'b0, 16'h0033, 16'h0044);
        checkOutput("wd_cleared", cam_timeout, 0);

        // Enable dropped mid-frame: that frame completes, the next is ignored.
        applyStimulus(100, 1'b1, 1'b1, 16'h0444, 16'h0555);
        applyStimulus(100, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Re-enable mid-frame: skip that frame, arm the following one.
        ds_before = ds_cnt;
        frame_valid_async = 1'b1;
        tick(50);
        enable = 1'b1;
        tick(50);
        frame_valid_async = 1'b0;
        tick(20);
        checkOutput("skip_no_start", ds_cnt, ds_before);
        applyStimulus(100, 1'b1, 1'b0, 16'h0055, 16'h0066);

        // Asynchronous reset while waiting for the detector.
        frame_valid_async = 1'b1;
        tick(100);
        frame_valid_async = 1'b0;
        tick(8);
        #2;
        reset_reset_n = 1'b0;
        #1;
        checkOutput("arst_coord_x", coord_x, 0);
        checkOutput("arst_coord_y", coord_y, 0);
        checkOutput("arst_hand", hand_present, 0);
        checkOutput("arst_frame_cnt", frame_cnt, 0);
        checkOutput("arst_err", err_done_timeout, 0);
        checkOutput("arst_det_start", det_start, 0);
        exp_x = '0; exp_y = '0; exp_cnt = '0; exp_hand = 1'b0; exp_miss = 0;
        tick(2);
        reset_reset_n = 1'b1;
        cv_before = cv_cnt;
        det_x    = 16'h0077;
        det_y    = 16'h0078;
        det_done = 1'b1;
        tick(5);
        det_done = 1'b0;
        tick(5);
        checkOutput("late_done_no_cv", cv_cnt, cv_before);
        checkOutput("late_done_cnt", frame_cnt, 0);
        applyStimulus(100, 1'b1, 1'b0, 16'h0088, 16'h0099);

        checkOutput("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
